// File: rtl/mem_defs_pkg.sv
// Shared memory-system definitions: access size encodings, controller FSM
// state encoding and the default top-of-memory byte address. Imported by
// the controller and by anything modelling the RAM side of the interface.
package mem_defs_pkg;

  localparam logic [1:0]  SIZE_BYTE        = 2'd1;
  localparam logic [1:0]  SIZE_WORD        = 2'd2;
  localparam logic [15:0] MEM_LAST_DEFAULT = 16'h07FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// CPU-to-RAM access controller. Accepts one byte/word load or store per
// request, range-checks it against MEM_LAST, issues a single RAM enable
// cycle and reports completion with a one-cycle O_done (O_fault marks a
// rejected request). All outputs are registered.
//   I_clk, I_reset_n        : clock, async active-low reset
//   I_req/I_we/I_size/I_signed/I_addr/I_wdata : CPU request (sampled in IDLE)
//   O_busy/O_done/O_fault/O_rdata              : CPU status and load data
//   O_ram_enable/write/size/addr/data, I_ram_data : RAM port
module mem_ctrl
  import mem_defs_pkg::*;
#(
  parameter logic [15:0] MEM_LAST = MEM_LAST_DEFAULT
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [1:0]  I_size,
  input  logic        I_signed,
  input  logic [15:0] I_addr,
  input  logic [15:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_fault,
  output logic [15:0] O_rdata,
  output logic        O_ram_enable,
  output logic        O_ram_write,
  output logic [1:0]  O_ram_size,
  output logic [15:0] O_ram_addr,
  output logic [15:0] O_ram_data,
  input  logic [15:0] I_ram_data
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic [1:0]  ram_size_q, ram_size_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_data_q, ram_data_d;
  logic        signed_q, signed_d;
  logic        legal;

  // A word needs addr+1 in range too, so a word at MEM_LAST is rejected.
  always_comb begin
    legal = ((I_size == SIZE_BYTE) || (I_size == SIZE_WORD)) &&
            (I_addr <= MEM_LAST) &&
            !((I_size == SIZE_WORD) && (I_addr == MEM_LAST));
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (I_req && legal) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ram_we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output values are derived from the next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    ram_en_d   = (state_d == ST_ISSUE);
    done_d     = 1'b0;
    fault_d    = 1'b0;
    rdata_d    = rdata_q;
    ram_we_d   = ram_we_q;
    ram_size_d = ram_size_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    signed_d   = signed_q;
    case (state_q)
      ST_IDLE: begin
        if (I_req) begin
          if (legal) begin
            ram_we_d   = I_we;
            ram_size_d = I_size;
            ram_addr_d = I_addr;
            ram_data_d = (I_size == SIZE_BYTE) ? {8'h00, I_wdata[7:0]} : I_wdata;
            signed_d   = I_signed;
          end else begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end
      ST_ISSUE: done_d = ram_we_q;
      ST_WAIT: begin
        done_d = 1'b1;
        if (ram_size_q == SIZE_BYTE)
          rdata_d = {{8{signed_q & I_ram_data[7]}}, I_ram_data[7:0]};
        else
          rdata_d = I_ram_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_size_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      signed_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_size_q <= ram_size_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      signed_q   <= signed_d;
    end
  end

  assign O_busy       = busy_q;
  assign O_done       = done_q;
  assign O_fault      = fault_q;
  assign O_rdata      = rdata_q;
  assign O_ram_enable = ram_en_q;
  assign O_ram_write  = ram_we_q;
  assign O_ram_size   = ram_size_q;
  assign O_ram_addr   = ram_addr_q;
  assign O_ram_data   = ram_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-addressed RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        I_req = 1'b0, I_we = 1'b0, I_signed = 1'b0;
  logic [1:0]  I_size = 2'd0;
  logic [15:0] I_addr = '0, I_wdata = '0;
  logic        O_busy, O_done, O_fault, O_ram_enable, O_ram_write;
  logic [15:0] O_rdata, O_ram_addr, O_ram_data;
  logic [1:0]  O_ram_size;
  logic [15:0] I_ram_data = '0;

  int tests_run = 0;
  int errors    = 0;

  mem_ctrl #(.MEM_LAST(16'h07FF)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_req(I_req), .I_we(I_we),
    .I_size(I_size), .I_signed(I_signed), .I_addr(I_addr), .I_wdata(I_wdata),
    .O_busy(O_busy), .O_done(O_done), .O_fault(O_fault), .O_rdata(O_rdata),
    .O_ram_enable(O_ram_enable), .O_ram_write(O_ram_write),
    .O_ram_size(O_ram_size), .O_ram_addr(O_ram_addr), .O_ram_data(O_ram_data),
    .I_ram_data(I_ram_data)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten bytes read as a fixed address-derived pattern.
  logic [7:0]  ram [0:2047];
  logic        wr  [0:2047];
  int          en_cnt = 0, done_cnt = 0;
  logic        last_we = 1'b0;
  logic [1:0]  last_size = '0;
  logic [15:0] last_addr = '0, last_data = '0;

  function automatic logic [7:0] rd_byte(input logic [10:0] a);
    logic [7:0] pat;
    pat = a[7:0] ^ 8'h3C;
    return wr[a] ? ram[a] : pat;
  endfunction

  always @(posedge clk) begin
    logic [10:0] a;
    a = O_ram_addr[10:0];
    if (O_done) done_cnt = done_cnt + 1;
    if (O_ram_enable) begin
      en_cnt    = en_cnt + 1;
      last_we   = O_ram_write;
      last_size = O_ram_size;
      last_addr = O_ram_addr;
      last_data = O_ram_data;
      if (O_ram_write) begin
        ram[a] = O_ram_data[7:0];
        wr[a]  = 1'b1;
        if (O_ram_size == 2'd2) begin
          ram[a + 11'd1] = O_ram_data[15:8];
          wr[a + 11'd1]  = 1'b1;
        end
      end else begin
        I_ram_data = {rd_byte(a + 11'd1), rd_byte(a)};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request; lat counts rising edges from the sampling edge to the
  // edge after which O_done is seen (99 on timeout).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output int ens, output logic fault);
    int e0;
    @(negedge clk);
    e0 = en_cnt;
    I_req = 1'b1; I_we = we; I_size = size; I_signed = sgn;
    I_addr = addr; I_wdata = wdata;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      I_req = 1'b0;
    end while (!O_done && lat < 10);
    fault = O_fault;
    if (!O_done) lat = 99;
    ens = en_cnt - e0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ens, e0, d0;
    logic        flt;
    logic [7:0]  busy_pat;
    logic [1:0]  ill_size [5];
    logic [15:0] ill_addr [5];

    for (int i = 0; i < 2048; i++) wr[i] = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_ctl", {O_busy, O_done, O_fault, O_ram_enable, O_ram_write, O_ram_size}, 0);
    check("rst_rdata", O_rdata, 0);
    check("rst_addr", O_ram_addr, 0);
    check("rst_data", O_ram_data, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // store word
    do_req(1'b1, 2'd2, 1'b0, 16'h0100, 16'hBEEF, lat, ens, flt);
    check("stw_lat", lat, 2);
    check("stw_fault", flt, 0);
    check("stw_ens", ens, 1);
    check("stw_ram", {last_we, last_size, last_addr, last_data}, {1'b1, 2'd2, 16'h0100, 16'hBEEF});

    // load word
    do_req(1'b0, 2'd2, 1'b0, 16'h0100, 16'h0000, lat, ens, flt);
    check("ldw_lat", lat, 3);
    check("ldw_ens", ens, 1);
    check("ldw_we", last_we, 0);
    check("ldw_rdata", O_rdata, 16'hBEEF);

    // byte store, then signed/unsigned byte loads
    do_req(1'b1, 2'd1, 1'b0, 16'h0200, 16'h1280, lat, ens, flt);
    check("stb_lat", lat, 2);
    check("stb_data", last_data, 16'h0080);
    do_req(1'b0, 2'd1, 1'b1, 16'h0200, 16'h0000, lat, ens, flt);
    check("ldbs_lat", lat, 3);
    check("ldbs_rdata", O_rdata, 16'hFF80);
    do_req(1'b0, 2'd1, 1'b0, 16'h0200, 16'h0000, lat, ens, flt);
    check("ldbu_rdata", O_rdata, 16'h0080);

    // illegal requests
    ill_size = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    ill_addr = '{16'h07FF, 16'h0800, 16'h0010, 16'h0010, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, ill_size[i], 1'b0, ill_addr[i], 16'h5555, lat, ens, flt);
      check($sformatf("ill%0d_lat", i), lat, 1);
      check($sformatf("ill%0d_fault", i), flt, 1);
      check($sformatf("ill%0d_ens", i), ens, 0);
    end
    check("ill_hold_addr", O_ram_addr, 16'h0200);

    // legal boundaries
    do_req(1'b1, 2'd1, 1'b0, 16'h07FF, 16'hC35A, lat, ens, flt);
    check("stb_last_lat", lat, 2);
    check("stb_last_fault", flt, 0);
    check("stb_last_data", last_data, 16'h005A);
    check("rdata_held", O_rdata, 16'h0080);
    do_req(1'b0, 2'd2, 1'b0, 16'h07FE, 16'h0000, lat, ens, flt);
    check("ldw_7fe_lat", lat, 3);
    check("ldw_7fe_rdata", O_rdata, 16'h5AC2);

    // reset during WAIT of a load
    @(negedge clk);
    I_req = 1'b1; I_we = 1'b0; I_size = 2'd2; I_addr = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    I_req = 1'b0;
    check("rsw_busy_issue", O_busy, 1);
    @(posedge clk);
    #2;
    check("rsw_wait", {O_busy, O_ram_enable}, 2'b10);
    e0 = en_cnt; d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rsw_ctl", {O_busy, O_done, O_fault, O_ram_enable, O_ram_write, O_ram_size}, 0);
    check("rsw_rdata", O_rdata, 0);
    check("rsw_ram", {O_ram_addr, O_ram_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rsw_no_done", done_cnt - d0, 0);
    check("rsw_no_en", en_cnt - e0, 0);
    do_req(1'b0, 2'd2, 1'b0, 16'h0100, 16'h0000, lat, ens, flt);
    check("rsw_ld_lat", lat, 3);
    check("rsw_ld_rdata", O_rdata, 16'hBEEF);

    // I_req held high across four back-to-back word stores
    @(negedge clk);
    e0 = en_cnt; d0 = done_cnt;
    I_req = 1'b1; I_we = 1'b1; I_size = 2'd2; I_signed = 1'b0;
    I_addr = 16'h0300; I_wdata = 16'h1234;
    busy_pat = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      busy_pat[k] = O_busy;
    end
    I_req = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_busy", busy_pat, 8'h55);
    check("b2b_ens", en_cnt - e0, 4);
    check("b2b_dones", done_cnt - d0, 4);
    do_req(1'b0, 2'd2, 1'b0, 16'h0300, 16'h0000, lat, ens, flt);
    check("b2b_ld_rdata", O_rdata, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAST, default 16'h07FF, meaning the highest valid byte address.
REQ-002 SHALL have port I_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port I_reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port I_req, input, 1 bit, the CPU request strobe; sampled only in IDLE.
REQ-005 SHALL have port I_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port I_size, input, 2 bits: 1 = byte, 2 = word; 0 and 3 are illegal.
REQ-007 SHALL have port I_signed, input, 1 bit, selecting sign-extension for byte loads.
REQ-008 SHALL have port I_addr, input, 16 bits, the byte address; word = low byte at addr, high byte at addr+1.
REQ-009 SHALL have port I_wdata, input, 16 bits, the store data.
REQ-010 SHALL have port O_busy, output, 1 bit, high in every state except IDLE.
REQ-011 SHALL have port O_done, output, 1 bit, a one-cycle completion pulse.
REQ-012 SHALL have port O_fault, output, 1 bit, qualifying O_done: the access was rejected.
REQ-013 SHALL have port O_rdata, output, 16 bits, the load result; held until the next load completes.
REQ-014 SHALL have ports O_ram_enable (1 bit), O_ram_write (1 bit), O_ram_size (2 bits), O_ram_addr (16 bits) and O_ram_data (16 bits), all outputs driving the RAM.
REQ-015 SHALL have port I_ram_data, input, 16 bits, the RAM read data, valid the cycle after an enabled read edge.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, with all outputs registered.
REQ-017 IDLE with I_req=1 SHALL latch I_we, I_size, I_signed, I_addr and I_wdata.
- If the request is legal: go to ISSUE.
- If illegal: stay in IDLE and pulse O_done=1, O_fault=1 in the next cycle; the RAM is not enabled.
REQ-018 A request SHALL be illegal when I_size is not 1 or 2, when I_addr > MEM_LAST, or when I_size=2 and I_addr = MEM_LAST.
REQ-019 In ISSUE, O_ram_enable SHALL be 1 for exactly one cycle, with O_ram_write, O_ram_size, O_ram_addr and O_ram_data from the latched values.
- Byte store: O_ram_data[15:8] = 0.
REQ-020 Store: ISSUE -> IDLE, with O_done=1, O_fault=0 in the following cycle; latency from request edge to O_done is 2 cycles.
REQ-021 Load: ISSUE -> WAIT, then on the WAIT edge capture I_ram_data into O_rdata and go to IDLE; O_done=1 in the next cycle; latency is 3 cycles.
REQ-022 Byte load SHALL give O_rdata = {8{I_ram_data[7]}, I_ram_data[7:0]} when I_signed=1, else {8'h00, I_ram_data[7:0]}.
REQ-023 Word load SHALL give O_rdata = I_ram_data unchanged.
REQ-024 I_req while O_busy=1 SHALL be ignored: not queued, not acknowledged.
REQ-025 A request presented in the cycle O_done=1 SHALL be accepted, allowing back-to-back operation.
REQ-026 O_ram_enable SHALL be 0 in IDLE and WAIT; the RAM interface outputs other than enable SHALL hold their last values.
REQ-027 Address arithmetic SHALL be 16-bit unsigned, with no wrap from MEM_LAST to 0.

Reset
REQ-028 On I_reset_n=0, asynchronously, the state SHALL go to IDLE and O_busy, O_done, O_fault and O_ram_enable SHALL be 0.
REQ-029 On I_reset_n=0, O_ram_write, O_ram_size, O_ram_addr, O_ram_data and O_rdata SHALL be 0.
REQ-030 Reset mid-operation SHALL abort the access, produce no O_done, and leave no further RAM enable.
REQ-031 After release of I_reset_n, the first rising edge SHALL sample I_req normally.

Structure
REQ-032 The size encodings (SIZE_BYTE=1, SIZE_WORD=2), the FSM state encodings and the MEM_LAST default SHALL live in a shared mem_defs include used by both the RAM and mem_ctrl.
REQ-033 The block SHALL be a single module with no sub-module; the range check and extension logic are local.

Verification
REQ-034 Store word 16'hBEEF at 16'h0100 -> one enable cycle with write=1, size=2, addr=16'h0100; O_done 2 cycles after the request; no fault.
REQ-035 Load word at 16'h0100 after REQ-034 -> O_rdata=16'hBEEF, O_done 3 cycles after the request.
REQ-036 Store byte 8'h80 at 16'h0200, then load byte signed -> O_rdata=16'hFF80; load byte unsigned -> O_rdata=16'h0080.
REQ-037 Word request at 16'h07FF, then byte request at 16'h0800, then size=3 -> each gives O_done=1, O_fault=1 next cycle, with O_ram_enable never asserted.
REQ-038 Assert I_reset_n=0 during WAIT of a load -> all outputs 0 immediately, no O_done; a load issued after release completes normally.
REQ-039 Hold I_req=1 continuously for four word stores -> one accept per 2 cycles, no dropped or duplicated RAM enables, and requests while busy ignored.
